cam_pixel_word_writer: RTL and testbench



---
 rtl/cam_writer_pkg.sv | 34 +++
 rtl/cam_pixel_lane_packer.sv | 78 +++++++
 rtl/cam_pixel_word_writer.sv | 153 +++++++++++++++
 tb/tb_cam_pixel_word_writer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_writer_pkg.sv
// -----------------------------------------------------------------------------
// cam_writer_pkg
// Shared types and helpers for the camera pixel word writer.
//   state_e   : writer FSM states (IDLE, PACK, FULL)
//   LANES     : byte lanes per memory word
//   BYTE_W    : width of one pixel / byte lane
//   lane_mask : byteenable for k filled lanes (lanes 0..k-1)
// -----------------------------------------------------------------------------
package cam_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    FULL = 2'd2
  } state_e;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;

  // Byteenable with the low k lanes set; out-of-range counts enable nothing.
  function automatic logic [LANES-1:0] lane_mask(input logic [2:0] k);
    logic [LANES-1:0] m;
    case (k)
      3'd0:    m = 4'b0000;
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      3'd4:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cam_pixel_lane_packer.sv
// -----------------------------------------------------------------------------
// cam_pixel_lane_packer
// Assembles pixels little-endian into 32-bit words and flags word completion.
//   clk, reset  : clock, synchronous active-high reset
//   take_i      : store pix_i in the next free lane
//   restart_i   : drop any partial word and store pix_i in lane 0
//   pix_i       : pixel byte
//   eof_i       : the stored pixel closes the frame (forces a commit)
//   commit_o    : the word (including pix_i) is complete this cycle
//   word_o      : assembled word including the current pixel
//   be_o        : byteenable of the assembled word
// -----------------------------------------------------------------------------
module cam_pixel_lane_packer
  import cam_writer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      take_i,
  input  logic                      restart_i,
  input  logic [BYTE_W-1:0]         pix_i,
  input  logic                      eof_i,
  output logic                      commit_o,
  output logic [LANES*BYTE_W-1:0]   word_o,
  output logic [LANES-1:0]          be_o
);

  logic [1:0]              lane_q, lane_d;
  logic [LANES*BYTE_W-1:0] data_q, data_d;
  logic [1:0]              lane_eff_s;
  logic [LANES*BYTE_W-1:0] word_s;
  logic                    load_s;

  // Lane selection, word assembly and next-state for the lane/data registers.
  always_comb begin
    load_s     = take_i | restart_i;
    lane_eff_s = lane_q;
    word_s     = data_q;
    // A restart behaves as if the buffer were empty: the pixel lands in lane 0.
    if (restart_i) begin
      lane_eff_s = 2'd0;
      word_s     = {(LANES*BYTE_W){1'b0}};
    end else begin
      lane_eff_s = lane_q;
      word_s     = data_q;
    end
    word_s[{lane_eff_s, 3'b000} +: BYTE_W] = pix_i;

    commit_o = load_s & ((lane_eff_s == 2'd3) | eof_i);
    be_o     = lane_mask({1'b0, lane_eff_s} + 3'd1);
    word_o   = word_s;

    lane_d = lane_q;
    data_d = data_q;
    // Committed words leave the packer empty so unfilled lanes read as zero.
    if (commit_o) begin
      lane_d = 2'd0;
      data_d = {(LANES*BYTE_W){1'b0}};
    end else if (load_s) begin
      lane_d = lane_eff_s + 2'd1;
      data_d = word_s;
    end else begin
      lane_d = lane_q;
      data_d = data_q;
    end
  end

  // Lane index and partial-word register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= 2'd0;
      data_q <= {(LANES*BYTE_W){1'b0}};
    end else begin
      lane_q <= lane_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/cam_pixel_word_writer.sv
// -----------------------------------------------------------------------------
// cam_pixel_word_writer
// Packs an 8-bit camera pixel stream into 32-bit words and writes them into a
// single-port frame buffer over Avalon-MM.
//   clk, reset        : clock, synchronous active-high reset
//   pix_data/valid    : pixel stream; pix_sof / pix_eof frame markers
//   pix_ready         : a pixel is accepted this cycle when valid & ready
//   rearm             : leaves FULL, clears overflow
//   mem_*             : Avalon-MM write master (registered, one-cycle strobe)
//   frame_done        : pulses with the strobe of the eof word
//   overflow          : sticky, set when the buffer fills without eof
//   words_written     : words committed in the current frame
// -----------------------------------------------------------------------------
module cam_pixel_word_writer
  import cam_writer_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BUF_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic              pix_eof,
  output logic              pix_ready,
  input  logic              rearm,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_WORDS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_data_q;
  logic              mem_wr_q;
  logic              frame_done_q;
  logic              overflow_q;
  logic [ADDR_W:0]   words_q;

  logic              xfer_s, restart_s, take_s, commit_s;
  logic [31:0]       word_s;
  logic [3:0]        be_s;

  assign pix_ready = (state_q != FULL) & ~reset;
  assign xfer_s    = pix_valid & pix_ready;
  // sof restarts a frame from IDLE or PACK; plain pixels only count inside a frame.
  assign restart_s = xfer_s & pix_sof;
  assign take_s    = xfer_s & ~pix_sof & (state_q == PACK);

  cam_pixel_lane_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .take_i    (take_s),
    .restart_i (restart_s),
    .pix_i     (pix_data),
    .eof_i     (pix_eof),
    .commit_o  (commit_s),
    .word_o    (word_s),
    .be_o      (be_s)
  );

  // Writer FSM with address counter and registered Avalon drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= {ADDR_W{1'b0}};
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_be_q     <= 4'b0000;
      mem_data_q   <= 32'h0000_0000;
      mem_wr_q     <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      words_q      <= {(ADDR_W+1){1'b0}};
    end else begin
      mem_wr_q     <= 1'b0;
      frame_done_q <= 1'b0;

      // Capture the committed word; the strobe appears in the following cycle.
      if (commit_s) begin
        mem_wr_q   <= 1'b1;
        mem_addr_q <= restart_s ? {ADDR_W{1'b0}} : addr_q;
        mem_be_q   <= be_s;
        mem_data_q <= word_s;
      end else begin
        mem_addr_q <= mem_addr_q;
        mem_be_q   <= mem_be_q;
        mem_data_q <= mem_data_q;
      end

      case (state_q)
        IDLE, PACK: begin
          if (restart_s) begin
            addr_q <= {ADDR_W{1'b0}};
            if (commit_s) begin
              // Single-pixel frame: one-byte word at address 0.
              words_q      <= (ADDR_W+1)'(1);
              frame_done_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              words_q <= {(ADDR_W+1){1'b0}};
              state_q <= PACK;
            end
          end else if (take_s && commit_s) begin
            words_q <= words_q + (ADDR_W+1)'(1);
            if (pix_eof) begin
              frame_done_q <= 1'b1;
              state_q      <= IDLE;
            end else if (addr_q == LAST_ADDR) begin
              overflow_q <= 1'b1;
              state_q    <= FULL;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end else begin
            state_q <= state_q;
          end
        end
        FULL: begin
          if (rearm) begin
            overflow_q <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            state_q    <= IDLE;
          end else begin
            state_q <= FULL;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_address    = mem_addr_q;
  assign mem_byteenable = mem_be_q;
  assign mem_chipselect = mem_wr_q;
  assign mem_write      = mem_wr_q;
  assign mem_writedata  = mem_data_q;
  assign mem_clken      = 1'b1;
  assign frame_done     = frame_done_q;
  assign overflow       = overflow_q;
  assign words_written  = words_q;

endmodule

// File: tb/tb_cam_pixel_word_writer.sv
module tb_cam_pixel_word_writer;

  localparam int ADDR_W    = 10;
  localparam int BUF_WORDS = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        pix_data = 8'h00;
  logic              pix_valid = 1'b0;
  logic              pix_sof = 1'b0;
  logic              pix_eof = 1'b0;
  logic              pix_ready;
  logic              rearm = 1'b0;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic              frame_done;
  logic              overflow;
  logic [ADDR_W:0]   words_written;

  always #5 clk = ~clk;

  cam_pixel_word_writer #(.ADDR_W(ADDR_W), .BUF_WORDS(BUF_WORDS)) dut (
    .clk(clk), .reset(reset),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .pix_ready(pix_ready), .rearm(rearm),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .frame_done(frame_done), .overflow(overflow), .words_written(words_written)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] be2mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // ---------------- behavioural reference model ----------------
  // mode: 0 = waiting for sof, 1 = inside a frame, 2 = buffer full
  int          m_mode = 0;
  logic [7:0]  m_pix[$];
  int          m_addr = 0;
  int          m_ww = 0;
  bit          m_wr = 0, m_fd = 0, m_ovf = 0;
  logic [9:0]  m_waddr = '0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_data = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_pix.delete(); m_addr = 0; m_ww = 0;
      m_wr = 0; m_fd = 0; m_ovf = 0;
    end else begin
      m_wr = 0; m_fd = 0;
      if (m_mode == 2) begin
        if (rearm) begin m_ovf = 0; m_addr = 0; m_mode = 0; end
      end else if (pix_valid) begin
        if (pix_sof) begin m_pix.delete(); m_addr = 0; m_ww = 0; m_mode = 1; end
        if (m_mode == 1) begin
          m_pix.push_back(pix_data);
          if (m_pix.size() == 4 || pix_eof) begin
            m_data = 32'h0;
            for (int i = 0; i < m_pix.size(); i++) m_data[8*i +: 8] = m_pix[i];
            m_be = 4'((1 << m_pix.size()) - 1);
            m_waddr = 10'(m_addr);
            m_wr = 1; m_ww++;
            m_pix.delete();
            if (pix_eof) begin m_fd = 1; m_mode = 0; end
            else if (m_addr == BUF_WORDS - 1) begin m_mode = 2; m_ovf = 1; end
            else m_addr++;
          end
        end
      end
    end
  end

  // ---------------- write log (for hand-computed expectations) ----------------
  typedef struct packed {
    logic [9:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
    logic        fd;
  } wr_t;
  wr_t wlog[$];

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    check("pix_ready", pix_ready, (m_mode != 2) && !reset);
    check("mem_write", mem_write, m_wr);
    check("mem_chipselect", mem_chipselect, m_wr);
    check("frame_done", frame_done, m_fd);
    check("overflow", overflow, m_ovf);
    check("words_written", words_written, 64'(m_ww));
    check("mem_clken", mem_clken, 1'b1);
    if (m_wr) begin
      check("mem_address", mem_address, m_waddr);
      check("mem_byteenable", mem_byteenable, m_be);
      check("mem_writedata", mem_writedata & be2mask(m_be), m_data);
    end
    if (mem_write) wlog.push_back({mem_address, mem_byteenable, mem_writedata, frame_done});
  end

  // ---------------- stimulus helpers ----------------
  task automatic px(input logic [7:0] d, input logic s, input logic e);
    pix_data = d; pix_sof = s; pix_eof = e; pix_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_wr(input string n, input int idx, input logic [9:0] a,
                          input logic [3:0] be, input logic [31:0] d, input logic fd);
    if (idx < wlog.size()) begin
      check({n, "_addr"}, wlog[idx].a, a);
      check({n, "_be"}, wlog[idx].be, be);
      check({n, "_data"}, wlog[idx].d & be2mask(be), d);
      check({n, "_frame_done"}, wlog[idx].fd, fd);
    end else begin
      check({n, "_present"}, 64'(wlog.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_address", mem_address, 10'h0);
    check("rst_byteenable", mem_byteenable, 4'h0);
    check("rst_writedata", mem_writedata, 32'h0);
    check("rst_clken", mem_clken, 1'b1);
    check("rst_ready", pix_ready, 1'b0);
    check("rst_words", words_written, 11'd0);
    reset = 1'b0;
    idle(1);

    // 8-pixel frame: two full words.
    wlog.delete();
    for (int i = 1; i <= 8; i++) px(8'(i), i == 1, i == 8);
    idle(2);
    check("f8_count", 64'(wlog.size()), 64'd2);
    check_wr("f8_w0", 0, 10'd0, 4'hF, 32'h04030201, 1'b0);
    check_wr("f8_w1", 1, 10'd1, 4'hF, 32'h08070605, 1'b1);
    check("f8_words", words_written, 11'd2);

    // 6-pixel frame: full word plus a two-lane partial word.
    wlog.delete();
    for (int i = 0; i < 6; i++) px(8'hA0 + 8'(i), i == 0, i == 5);
    idle(2);
    check("f6_count", 64'(wlog.size()), 64'd2);
    check_wr("f6_w0", 0, 10'd0, 4'hF, 32'hA3A2A1A0, 1'b0);
    check_wr("f6_w1", 1, 10'd1, 4'h3, 32'h0000A5A4, 1'b1);

    // Mid-frame sof drops the partial word 0x11,0x22.
    wlog.delete();
    px(8'h11, 1'b1, 1'b0); px(8'h22, 1'b0, 1'b0);
    px(8'h33, 1'b1, 1'b0); px(8'h44, 1'b0, 1'b0); px(8'h55, 1'b0, 1'b0); px(8'h66, 1'b0, 1'b0);
    px(8'h77, 1'b0, 1'b1);
    idle(2);
    check("sof_count", 64'(wlog.size()), 64'd2);
    check_wr("sof_w0", 0, 10'd0, 4'hF, 32'h66554433, 1'b0);
    check_wr("sof_w1", 1, 10'd1, 4'h1, 32'h00000077, 1'b1);

    // 20 pixels without eof fill the 4-word buffer.
    wlog.delete();
    for (int i = 0; i < 20; i++) px(8'h80 + 8'(i), i == 0, 1'b0);
    idle(1);
    check("ovf_count", 64'(wlog.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'h80 + 8'(4*k + b);
      check_wr("ovf_w", k, 10'(k), 4'hF, w, 1'b0);
    end
    check("ovf_flag", overflow, 1'b1);
    check("ovf_ready", pix_ready, 1'b0);
    rearm = 1'b1; @(posedge clk); #1; rearm = 1'b0;
    check("rearm_flag", overflow, 1'b0);
    check("rearm_ready", pix_ready, 1'b1);

    // Single-pixel frame.
    wlog.delete();
    px(8'h5A, 1'b1, 1'b1);
    idle(2);
    check("one_count", 64'(wlog.size()), 64'd1);
    check_wr("one_w0", 0, 10'd0, 4'h1, 32'h0000005A, 1'b1);

    // Reset arrives with the pixel that would complete the word: nothing is written.
    wlog.delete();
    px(8'h01, 1'b1, 1'b0); px(8'h02, 1'b0, 1'b0); px(8'h03, 1'b0, 1'b0);
    pix_data = 8'h04; pix_valid = 1'b1; pix_sof = 1'b0; pix_eof = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_write", mem_write, 1'b0);
    check("rst_mid_ready", pix_ready, 1'b0);
    check("rst_mid_words", words_written, 11'd0);
    idle(1);
    check("rst_mid_write2", mem_write, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) px(8'hC0 + 8'(i), i == 0, i == 3);
    idle(2);
    check("rst_after_count", 64'(wlog.size()), 64'd1);
    check_wr("rst_after_w0", 0, 10'd0, 4'hF, 32'hC3C2C1C0, 1'b1);

    // Randomised traffic checked against the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      pix_valid = ($urandom % 4) != 0;
      pix_data  = 8'($urandom);
      pix_sof   = ($urandom % 16) == 0;
      pix_eof   = ($urandom % 10) == 0;
      rearm     = ($urandom % 20) == 0;
      reset     = ($urandom % 500) == 0;
      @(posedge clk); #1;
    end
    reset = 1'b0; rearm = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
